// File: rtl/bus_source_mux.sv
// ============================================================================
// Module   : bus_source_mux
// Purpose  : Registered datapath bus mux with a ready-wait timeout, immediate
//            formatting and a valid/ack handshake toward the consumer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_source_mux #(
   parameter int DATA_W  = 16,
   parameter int N_SRC   = 8,
   parameter int SEL_W   = 3,
   parameter int IMM_W   = 9,
   parameter int TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sel_valid,
   input  logic [SEL_W-1:0]        sel_src,
   input  logic [1:0]              sel_mode,
   input  logic [N_SRC*DATA_W-1:0] src_data,
   input  logic [N_SRC-1:0]        src_ready,
   input  logic                    bus_ack,
   output logic [DATA_W-1:0]       bus_out,
   output logic                    bus_valid,
   output logic [SEL_W-1:0]        bus_src,
   output logic                    busy,
   output logic                    err_sel,
   output logic                    err_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam int PAD_W = DATA_W - IMM_W;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_DRIVE = 2'd2;

   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_ZEXT = 2'b01;
   localparam logic [1:0] MODE_TOP  = 2'b10;

   logic [1:0]        state_q,       state_d;
   logic [SEL_W-1:0]  src_q,         src_d;
   logic [1:0]        mode_q,        mode_d;
   logic [CNT_W-1:0]  cnt_q,         cnt_d;
   logic [DATA_W-1:0] bus_out_q,     bus_out_d;
   logic              bus_valid_q,   bus_valid_d;
   logic [SEL_W-1:0]  bus_src_q,     bus_src_d;
   logic              err_sel_q,     err_sel_d;
   logic              err_timeout_q, err_timeout_d;

   logic [DATA_W-1:0] sel_word;
   logic              sel_rdy;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] fmt_word;
   logic              sel_illegal;

   // Source selection always uses the latched index, never the live sel_src.
   always_comb begin
      sel_word = '0;
      sel_rdy  = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         if (src_q == SEL_W'(k)) begin
            sel_word = src_data[k*DATA_W +: DATA_W];
            sel_rdy  = src_ready[k];
         end
      end
   end

   always_comb begin
      imm = sel_word[IMM_W-1:0];
      case (mode_q)
         MODE_PASS: fmt_word = sel_word;
         MODE_ZEXT: fmt_word = {{PAD_W{1'b0}}, imm};
         MODE_TOP:  fmt_word = {imm, {PAD_W{1'b0}}};
         default:   fmt_word = {{PAD_W{imm[IMM_W-1]}}, imm};
      endcase
   end

   assign sel_illegal = ({1'b0, sel_src} >= (SEL_W+1)'(N_SRC));

   always_comb begin
      state_d       = state_q;
      src_d         = src_q;
      mode_d        = mode_q;
      cnt_d         = cnt_q;
      bus_out_d     = bus_out_q;
      bus_valid_d   = bus_valid_q;
      bus_src_d     = bus_src_q;
      err_sel_d     = 1'b0;
      err_timeout_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (sel_valid) begin
               if (sel_illegal) begin
                  err_sel_d = 1'b1;
               end else begin
                  src_d   = sel_src;
                  mode_d  = sel_mode;
                  cnt_d   = '0;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (sel_rdy) begin
               bus_out_d   = fmt_word;
               bus_src_d   = src_q;
               bus_valid_d = 1'b1;
               state_d     = ST_DRIVE;
            end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
               cnt_d         = '0;
               err_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DRIVE: begin
            if (bus_ack) begin
               bus_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            bus_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         src_q         <= '0;
         mode_q        <= '0;
         cnt_q         <= '0;
         bus_out_q     <= '0;
         bus_valid_q   <= 1'b0;
         bus_src_q     <= '0;
         err_sel_q     <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         src_q         <= src_d;
         mode_q        <= mode_d;
         cnt_q         <= cnt_d;
         bus_out_q     <= bus_out_d;
         bus_valid_q   <= bus_valid_d;
         bus_src_q     <= bus_src_d;
         err_sel_q     <= err_sel_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign bus_out     = bus_out_q;
   assign bus_valid   = bus_valid_q;
   assign bus_src     = bus_src_q;
   assign busy        = (state_q != ST_IDLE);
   assign err_sel     = err_sel_q;
   assign err_timeout = err_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_source_mux.sv
// ============================================================================
// Module   : tb_bus_source_mux
// Purpose  : Directed, table-driven self-checking bench for bus_source_mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_source_mux;

   localparam int DATA_W  = 16;
   localparam int N_SRC   = 6;
   localparam int SEL_W   = 3;
   localparam int IMM_W   = 9;
   localparam int TIMEOUT = 15;

   logic                    clk;
   logic                    rst_n;
   logic                    sel_valid;
   logic [SEL_W-1:0]        sel_src;
   logic [1:0]              sel_mode;
   logic [N_SRC*DATA_W-1:0] src_data;
   logic [N_SRC-1:0]        src_ready;
   logic                    bus_ack;
   logic [DATA_W-1:0]       bus_out;
   logic                    bus_valid;
   logic [SEL_W-1:0]        bus_src;
   logic                    busy;
   logic                    err_sel;
   logic                    err_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   bus_source_mux #(
      .DATA_W (DATA_W),
      .N_SRC  (N_SRC),
      .SEL_W  (SEL_W),
      .IMM_W  (IMM_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sel_valid  (sel_valid),
      .sel_src    (sel_src),
      .sel_mode   (sel_mode),
      .src_data   (src_data),
      .src_ready  (src_ready),
      .bus_ack    (bus_ack),
      .bus_out    (bus_out),
      .bus_valid  (bus_valid),
      .bus_src    (bus_src),
      .busy       (busy),
      .err_sel    (err_sel),
      .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [SEL_W-1:0]  src;
      logic [1:0]        mode;
      logic [DATA_W-1:0] word;
      logic [DATA_W-1:0] exp_out;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Issue one request pulse; returns at the negedge after the accepting edge.
   task automatic request(input logic [SEL_W-1:0] s, input logic [1:0] m);
      sel_valid = 1'b1;
      sel_src   = s;
      sel_mode  = m;
      cyc();
      sel_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n;
      n = 0;
      while (bus_valid !== 1'b1 && n < budget) begin
         cyc();
         n++;
      end
      check(name, {31'd0, bus_valid}, 32'd1);
   endtask

   task automatic ack_and_check(input string name);
      bus_ack = 1'b1;
      cyc();
      bus_ack = 1'b0;
      check({name, "_valid_drop"}, {31'd0, bus_valid}, 32'd0);
      check({name, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [DATA_W-1:0] prev;

      vecs[0] = '{3'd3, 2'b01, 16'h01A5, 16'h01A5};
      vecs[1] = '{3'd3, 2'b10, 16'h01A5, 16'hD280};
      vecs[2] = '{3'd3, 2'b11, 16'h01A5, 16'hFFA5};
      vecs[3] = '{3'd5, 2'b00, 16'h1234, 16'h1234};
      vecs[4] = '{3'd0, 2'b11, 16'h00FF, 16'h00FF};
      vecs[5] = '{3'd0, 2'b10, 16'hFFFF, 16'hFF80};
      vecs[6] = '{3'd5, 2'b11, 16'hABCD, 16'hFFCD};

      rst_n     = 1'b0;
      sel_valid = 1'b0;
      sel_src   = '0;
      sel_mode  = 2'b00;
      src_data  = '0;
      src_ready = '0;
      bus_ack   = 1'b0;
      cyc();
      cyc();
      check("rst_bus_out", {16'd0, bus_out}, 32'd0);
      check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
      check("rst_bus_src", {29'd0, bus_src}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err_sel", {31'd0, err_sel}, 32'd0);
      check("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
      rst_n = 1'b1;
      cyc();

      // Pass mode with ready already high: data two cycles after the request.
      src_data[2*DATA_W +: DATA_W] = 16'hBEEF;
      src_ready = 6'b000100;
      request(3'd2, 2'b00);
      check("pass_busy", {31'd0, busy}, 32'd1);
      check("pass_no_valid_yet", {31'd0, bus_valid}, 32'd0);
      cyc();
      check("pass_valid", {31'd0, bus_valid}, 32'd1);
      check("pass_out", {16'd0, bus_out}, 32'h0000BEEF);
      check("pass_src", {29'd0, bus_src}, 32'd2);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("pass_hold_out", {16'd0, bus_out}, 32'h0000BEEF);
         check("pass_hold_valid", {31'd0, bus_valid}, 32'd1);
      end
      ack_and_check("pass");

      // Formatting vectors.
      src_ready = '1;
      for (int v = 0; v < 7; v++) begin
         src_data[vecs[v].src*DATA_W +: DATA_W] = vecs[v].word;
         request(vecs[v].src, vecs[v].mode);
         cyc();
         check("vec_valid", {31'd0, bus_valid}, 32'd1);
         check("vec_out", {16'd0, bus_out}, {16'd0, vecs[v].exp_out});
         check("vec_src", {29'd0, bus_src}, {29'd0, vecs[v].src});
         ack_and_check("vec");
      end

      // Ready rises five cycles after the request.
      src_ready = '0;
      src_data[4*DATA_W +: DATA_W] = 16'h5A5A;
      request(3'd4, 2'b00);
      for (int i = 0; i < 4; i++) cyc();
      check("delay_not_valid", {31'd0, bus_valid}, 32'd0);
      src_ready[4] = 1'b1;
      cyc();
      check("delay_valid", {31'd0, bus_valid}, 32'd1);
      check("delay_out", {16'd0, bus_out}, 32'h00005A5A);
      check("delay_no_timeout", {31'd0, err_timeout}, 32'd0);
      ack_and_check("delay");

      // Timeout: ready never rises for source 1.
      src_ready = '0;
      prev = bus_out;
      src_data[1*DATA_W +: DATA_W] = 16'h1111;
      request(3'd1, 2'b00);
      for (int i = 0; i < TIMEOUT - 1; i++) cyc();
      check("to_still_busy", {31'd0, busy}, 32'd1);
      check("to_not_yet", {31'd0, err_timeout}, 32'd0);
      cyc();
      check("to_pulse", {31'd0, err_timeout}, 32'd1);
      check("to_idle", {31'd0, busy}, 32'd0);
      check("to_bus_kept", {16'd0, bus_out}, {16'd0, prev});
      check("to_no_valid", {31'd0, bus_valid}, 32'd0);
      cyc();
      check("to_pulse_end", {31'd0, err_timeout}, 32'd0);

      // Illegal selects (N_SRC = 6).
      request(3'd7, 2'b00);
      check("sel7_err", {31'd0, err_sel}, 32'd1);
      check("sel7_busy", {31'd0, busy}, 32'd0);
      check("sel7_valid", {31'd0, bus_valid}, 32'd0);
      cyc();
      check("sel7_pulse_end", {31'd0, err_sel}, 32'd0);
      request(3'd6, 2'b00);
      check("sel6_err", {31'd0, err_sel}, 32'd1);
      check("sel6_bus_kept", {16'd0, bus_out}, {16'd0, prev});
      cyc();

      // Requests while busy are ignored; ready of live sel_src is ignored.
      src_data[1*DATA_W +: DATA_W] = 16'hC0DE;
      src_data[3*DATA_W +: DATA_W] = 16'h3333;
      src_ready = 6'b001000;
      request(3'd1, 2'b00);
      sel_valid = 1'b1;
      sel_src   = 3'd3;
      cyc();
      cyc();
      check("busy_wait_ignored", {31'd0, bus_valid}, 32'd0);
      check("busy_wait_busy", {31'd0, busy}, 32'd1);
      src_ready[1] = 1'b1;
      cyc();
      check("busy_first_valid", {31'd0, bus_valid}, 32'd1);
      check("busy_first_out", {16'd0, bus_out}, 32'h0000C0DE);
      check("busy_first_src", {29'd0, bus_src}, 32'd1);
      cyc();
      check("busy_drive_hold", {16'd0, bus_out}, 32'h0000C0DE);
      sel_valid = 1'b0;
      ack_and_check("busy");
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("busy_no_second", {31'd0, bus_valid}, 32'd0);
      end

      // Asynchronous reset while driving.
      src_data[2*DATA_W +: DATA_W] = 16'h7777;
      src_ready = 6'b000100;
      request(3'd2, 2'b00);
      wait_valid("arst_reach_drive", 5);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_out", {16'd0, bus_out}, 32'd0);
      check("arst_valid", {31'd0, bus_valid}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_src", {29'd0, bus_src}, 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();
      check("arst_stays_idle", {31'd0, bus_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
